// File: rtl/ctrl_pulse_sequencer_pkg.sv
// Shared types and constants for the control-leaf pulse sequencer.
package ctrl_pulse_sequencer_pkg;

  localparam int CMD_LEN_W   = 8;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [2:0]           bits;
    logic [CMD_LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ctrl_pulse_sequencer_if.sv
// Command, leaf and response signals of the pulse sequencer; master = command source and leaf, slave = sequencer.
interface ctrl_pulse_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [2:0]       i_cmd_bits;
  logic [LEN_W-1:0] i_cmd_len;
  logic             o_a;
  logic             o_b;
  logic             o_c;
  logic             i_d;
  logic             i_e;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [LEN_W:0]   o_rsp_dcnt;
  logic             o_rsp_e;
  logic             o_busy;

  modport master (
    output i_cmd_valid, i_cmd_bits, i_cmd_len, i_d, i_e, i_rsp_ready,
    input  o_cmd_ready, o_a, o_b, o_c, o_rsp_valid, o_rsp_dcnt, o_rsp_e, o_busy
  );

  modport slave (
    input  i_cmd_valid, i_cmd_bits, i_cmd_len, i_d, i_e, i_rsp_ready,
    output o_cmd_ready, o_a, o_b, o_c, o_rsp_valid, o_rsp_dcnt, o_rsp_e, o_busy
  );
endinterface

// File: rtl/ctrl_pulse_sequencer_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module ctrl_pulse_sequencer_fifo
  import ctrl_pulse_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  cmd_t i_wdata,
  input  logic i_pop,
  output cmd_t o_rdata,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  // NOTE: storage is not reset; the pointers alone define which entries are valid, so the array stays plain RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

  // NOTE: flops use <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign o_rdata = mem[rd_ptr[AW-1:0]];
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ctrl_pulse_sequencer.sv
// Queues {pattern, hold} commands, drives each onto a control leaf and returns d-count / sticky-e per command.
// Build option CTRL_PULSE_SEQUENCER_STATUS_SYNC_EN: 2-flop status synchroniser plus a DRAIN state.
module ctrl_pulse_sequencer
  import ctrl_pulse_sequencer_pkg::*;
#(
  parameter int         DEPTH        = 4,
  parameter int         LEN_W        = CMD_LEN_W,
  parameter logic [2:0] DEFAULT_BITS = 3'b000
) (
  input logic                   i_clk,
  input logic                   i_rst,
  ctrl_pulse_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRIVE = DRIVE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_RESP  = RESP;

  logic [1:0]       state;
  logic [2:0]       drive_q;
  logic [LEN_W-1:0] hold_cnt;
  logic [LEN_W:0]   dcnt;
  logic             e_seen;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             d_s;
  logic             e_s;
  logic             acc_en;
  cmd_t             wr_cmd;
  cmd_t             head;

  assign push   = bus.i_cmd_valid & ~full;
  assign pop    = (state == S_IDLE) & ~empty;
  assign wr_cmd = '{bits: bus.i_cmd_bits, len: bus.i_cmd_len};

  ctrl_pulse_sequencer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_wdata(wr_cmd),
    .i_pop  (pop),
    .o_rdata(head),
    .o_full (full),
    .o_empty(empty)
  );

`ifdef CTRL_PULSE_SEQUENCER_STATUS_SYNC_EN
  logic [SYNC_STAGES-1:0] d_sync;
  logic [SYNC_STAGES-1:0] e_sync;
  logic [SYNC_STAGES-1:0] drv_pipe;

  // drv_pipe delays "in DRIVE" by the synchroniser depth so accumulation lines up with the driven pattern.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_sync   <= '0;
      e_sync   <= '0;
      drv_pipe <= '0;
    end else begin
      d_sync   <= {d_sync[SYNC_STAGES-2:0], bus.i_d};
      e_sync   <= {e_sync[SYNC_STAGES-2:0], bus.i_e};
      drv_pipe <= {drv_pipe[SYNC_STAGES-2:0], state == S_DRIVE};
    end
  end

  assign d_s    = d_sync[SYNC_STAGES-1];
  assign e_s    = e_sync[SYNC_STAGES-1];
  assign acc_en = drv_pipe[SYNC_STAGES-1];
`else
  assign d_s    = bus.i_d;
  assign e_s    = bus.i_e;
  assign acc_en = (state == S_DRIVE);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      drive_q  <= DEFAULT_BITS;
      hold_cnt <= '0;
      dcnt     <= '0;
      e_seen   <= 1'b0;
    end else begin
      if (pop) begin
        dcnt   <= '0;
        e_seen <= 1'b0;
      end else if (acc_en) begin
        dcnt   <= dcnt + {{LEN_W{1'b0}}, d_s};
        e_seen <= e_seen | e_s;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            drive_q  <= head.bits;
            hold_cnt <= head.len;
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (hold_cnt == '0) begin
            // The pattern ends with the window; the synced build keeps sampling in DRAIN with idle outputs.
            drive_q <= DEFAULT_BITS;
`ifdef CTRL_PULSE_SEQUENCER_STATUS_SYNC_EN
            hold_cnt <= LEN_W'(SYNC_STAGES - 1);
            state    <= S_DRAIN;
`else
            state    <= S_RESP;
`endif
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
`ifdef CTRL_PULSE_SEQUENCER_STATUS_SYNC_EN
          if (hold_cnt == '0) state <= S_RESP;
          else                hold_cnt <= hold_cnt - 1'b1;
`else
          state <= S_IDLE;
`endif
        end
        S_RESP: begin
          if (bus.i_rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_a         = drive_q[0];
  assign bus.o_b         = drive_q[1];
  assign bus.o_c         = drive_q[2];
  assign bus.o_cmd_ready = ~full;
  assign bus.o_rsp_valid = (state == S_RESP);
  assign bus.o_rsp_dcnt  = dcnt;
  assign bus.o_rsp_e     = e_seen;
  assign bus.o_busy      = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_ctrl_pulse_sequencer.sv
// Directed bench for ctrl_pulse_sequencer: reset, window timing, backpressure, length limits, async reset.
module tb_ctrl_pulse_sequencer;
  localparam int         DEPTH = 4;
  localparam int         LEN_W = 8;
  localparam logic [2:0] DEF   = 3'b101;
`ifdef CTRL_PULSE_SEQUENCER_STATUS_SYNC_EN
  localparam int DRAIN_CYC = 2;
`else
  localparam int DRAIN_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [2:0] abc;

  ctrl_pulse_sequencer_if #(.LEN_W(LEN_W)) bus ();

  ctrl_pulse_sequencer #(
    .DEPTH       (DEPTH),
    .LEN_W       (LEN_W),
    .DEFAULT_BITS(DEF)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign abc = {bus.o_c, bus.o_b, bus.o_a};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!bus.o_rsp_valid && n < budget) begin
      tick();
      n++;
    end
    check("rsp_wait", 32'(bus.o_rsp_valid), 32'd1);
  endtask

  task automatic release_rsp();
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_bits  = 3'b000;
    bus.i_cmd_len   = '0;
    bus.i_d         = 1'b0;
    bus.i_e         = 1'b0;
    bus.i_rsp_ready = 1'b0;

    // Reset and idle
    tick();
    tick();
    check("rst_abc", 32'(abc), 32'(DEF));
    rst = 1'b0;
    repeat (5) tick();
    check("idle_abc",   32'(abc), 32'(DEF));
    check("idle_ready", 32'(bus.o_cmd_ready), 32'd1);
    check("idle_busy",  32'(bus.o_busy), 32'd0);
    check("idle_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("idle_dcnt",  32'(bus.o_rsp_dcnt), 32'd0);
    check("idle_e",     32'(bus.o_rsp_e), 32'd0);

    // Single command 011 / len 3: d high in window cycles 1 and 3, e pulse in cycle 2
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_bits  = 3'b011;
    bus.i_cmd_len   = 8'd3;
    tick();
    bus.i_cmd_valid = 1'b0;
    check("t2_pre_abc",  32'(abc), 32'(DEF));
    check("t2_pre_busy", 32'(bus.o_busy), 32'd1);
    tick();
    for (int w = 0; w < 4; w++) begin
      bus.i_d = (w == 1) || (w == 3);
      bus.i_e = (w == 2);
      check("t2_drive_abc", 32'(abc), 32'h3);
      check("t2_drive_valid", 32'(bus.o_rsp_valid), 32'd0);
      tick();
    end
    bus.i_d = 1'b0;
    bus.i_e = 1'b0;
    check("t2_post_abc", 32'(abc), 32'(DEF));
    n = 0;
    while (!bus.o_rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check("t2_rsp_lat",  32'(n), 32'(DRAIN_CYC));
    check("t2_dcnt",     32'(bus.o_rsp_dcnt), 32'd2);
    check("t2_e",        32'(bus.o_rsp_e), 32'd1);
    check("t2_rsp_abc",  32'(abc), 32'(DEF));
    release_rsp();
    check("t2_valid_clr", 32'(bus.o_rsp_valid), 32'd0);
    check("t2_busy_clr",  32'(bus.o_busy), 32'd0);

    // Backpressure: five commands (len 0..4, d held high) fill the queue while the first waits in RESP
    bus.i_d         = 1'b1;
    bus.i_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_cmd_bits = 3'(i + 1);
      bus.i_cmd_len  = 8'(i);
      check("t3_ready", 32'(bus.o_cmd_ready), 32'd1);
      tick();
    end
    bus.i_cmd_bits = 3'b111;
    bus.i_cmd_len  = 8'd9;
    check("t3_full", 32'(bus.o_cmd_ready), 32'd0);
    tick();
    tick();
    check("t3_blocked", 32'(bus.o_cmd_ready), 32'd0);
    bus.i_cmd_valid = 1'b0;
    wait_rsp(20);
    check("t3_rsp0_dcnt", 32'(bus.o_rsp_dcnt), 32'd1);
    check("t3_rsp0_busy", 32'(bus.o_busy), 32'd1);
    release_rsp();
    check("t3_pop_full_ready", 32'(bus.o_cmd_ready), 32'd0);
    tick();
    check("t3_after_pop_ready", 32'(bus.o_cmd_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      wait_rsp(40);
      check("t3_rsp_dcnt", 32'(bus.o_rsp_dcnt), 32'(k + 1));
      check("t3_rsp_e",    32'(bus.o_rsp_e), 32'd0);
      release_rsp();
    end
    check("t3_busy_end", 32'(bus.o_busy), 32'd0);

    // Length limits with d held high
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_bits  = 3'b010;
    bus.i_cmd_len   = 8'd0;
    tick();
    bus.i_cmd_valid = 1'b0;
    check("t4_len0_pre", 32'(abc), 32'(DEF));
    tick();
    check("t4_len0_drv", 32'(abc), 32'h2);
    tick();
    check("t4_len0_post", 32'(abc), 32'(DEF));
    wait_rsp(10);
    check("t4_len0_dcnt", 32'(bus.o_rsp_dcnt), 32'd1);
    release_rsp();

    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_bits  = 3'b100;
    bus.i_cmd_len   = 8'd255;
    tick();
    bus.i_cmd_valid = 1'b0;
    wait_rsp(300);
    check("t4_len255_dcnt", 32'(bus.o_rsp_dcnt), 32'd256);
    release_rsp();
    bus.i_d = 1'b0;

    // Asynchronous reset in the middle of a DRIVE window with a second command queued
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_bits  = 3'b110;
    bus.i_cmd_len   = 8'd20;
    tick();
    bus.i_cmd_bits  = 3'b001;
    bus.i_cmd_len   = 8'd2;
    tick();
    bus.i_cmd_valid = 1'b0;
    check("t5_drv_abc", 32'(abc), 32'h6);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_async_abc",   32'(abc), 32'(DEF));
    check("t5_async_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("t5_async_busy",  32'(bus.o_busy), 32'd0);
    check("t5_async_ready", 32'(bus.o_cmd_ready), 32'd1);
    #2 rst = 1'b0;
    tick();
    tick();
    check("t5_post_busy",  32'(bus.o_busy), 32'd0);
    check("t5_post_abc",   32'(abc), 32'(DEF));
    check("t5_post_valid", 32'(bus.o_rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
